// File: rtl/biquad_cascade.sv
// Cascade of direct-form-II biquad sections sharing one multiplier and one accumulator.
// Each section takes six cycles; the result is registered on yk with a one-cycle done pulse.
module biquad_cascade #(
  parameter int unsigned N        = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned SECTIONS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [N-1:0]           uk,
  input  logic                          coef_we,
  input  logic [$clog2(5*SECTIONS)-1:0] coef_addr,
  input  logic signed [N-1:0]           coef_data,
  input  logic                          clr_state,
  output logic                          busy,
  output logic                          done,
  output logic signed [N-1:0]           yk,
  output logic                          ovf
);

  localparam int unsigned AW   = $clog2(5*SECTIONS);
  localparam int unsigned SW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int unsigned NC   = 5*SECTIONS;
  localparam int unsigned AccW = N + 4;
  localparam int unsigned PW   = 2*N;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q;
  logic [2:0]             ph_q;
  logic [SW-1:0]          sec_q;
  logic [AW-1:0]          cbase_q;
  logic signed [N-1:0]    coef_q [NC];
  logic signed [N-1:0]    f1_q [SECTIONS];
  logic signed [N-1:0]    f2_q [SECTIONS];
  logic signed [N-1:0]    x_q;
  logic signed [N-1:0]    f_q;
  logic signed [AccW-1:0] acc_q;

  logic signed [N-1:0]    mc, md;
  logic signed [PW-1:0]   prod, prod_sh;
  logic signed [AccW-1:0] pterm, sum_add, sum_sub;

  function automatic logic fits(input logic signed [AccW-1:0] v);
    return v[AccW-1:N-1] == {(AccW-N+1){v[AccW-1]}};
  endfunction

  function automatic logic signed [N-1:0] sat(input logic signed [AccW-1:0] v);
    if (fits(v)) return v[N-1:0];
    else if (v[AccW-1]) return {1'b1, {(N-1){1'b0}}};
    else return {1'b0, {(N-1){1'b1}}};
  endfunction

  // Operand selection for the single shared multiplier, keyed by phase.
  always_comb begin
    mc = '0;
    md = '0;
    case (ph_q)
      3'd1: begin mc = coef_q[cbase_q + AW'(3)]; md = f1_q[sec_q]; end
      3'd2: begin mc = coef_q[cbase_q + AW'(4)]; md = f2_q[sec_q]; end
      3'd3: begin mc = coef_q[cbase_q + AW'(1)]; md = f1_q[sec_q]; end
      3'd4: begin mc = coef_q[cbase_q + AW'(2)]; md = f2_q[sec_q]; end
      3'd5: begin mc = coef_q[cbase_q];          md = f_q;         end
      default: ;
    endcase
  end

  // Sign-extended operands make the low 2N bits of the unsigned product the signed product.
  assign prod    = {{N{mc[N-1]}}, mc} * {{N{md[N-1]}}, md};
  assign prod_sh = prod >>> FRAC;
  assign pterm   = prod_sh[AccW-1:0];
  assign sum_add = acc_q + pterm;
  assign sum_sub = acc_q - pterm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ph_q    <= '0;
      sec_q   <= '0;
      cbase_q <= '0;
      x_q     <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      yk      <= '0;
      ovf     <= 1'b0;
      for (int i = 0; i < NC; i++) coef_q[i] <= (i % 5 == 0) ? N'(1 << FRAC) : '0;
      for (int s = 0; s < SECTIONS; s++) begin
        f1_q[s] <= '0;
        f2_q[s] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (coef_we && (32'(coef_addr) < NC)) coef_q[coef_addr] <= coef_data;
          if (clr_state) begin
            for (int s = 0; s < SECTIONS; s++) begin
              f1_q[s] <= '0;
              f2_q[s] <= '0;
            end
          end
          if (start) begin
            x_q     <= uk;
            state_q <= StRun;
            busy    <= 1'b1;
            ph_q    <= '0;
            sec_q   <= '0;
            cbase_q <= '0;
          end
        end
        StRun: begin
          ph_q <= ph_q + 3'd1;
          case (ph_q)
            3'd0: acc_q <= {{(AccW-N){x_q[N-1]}}, x_q};
            3'd1, 3'd2: acc_q <= sum_sub;
            3'd3: begin
              f_q   <= sat(acc_q);
              ovf   <= ovf | ~fits(acc_q);
              acc_q <= pterm;
            end
            3'd4: acc_q <= sum_add;
            3'd5: begin
              x_q          <= sat(sum_add);
              ovf          <= ovf | ~fits(sum_add);
              f2_q[sec_q]  <= f1_q[sec_q];
              f1_q[sec_q]  <= f_q;
              ph_q         <= '0;
              if (sec_q == SW'(SECTIONS - 1)) begin
                state_q <= StDone;
              end else begin
                sec_q   <= sec_q + SW'(1);
                cbase_q <= cbase_q + AW'(5);
              end
            end
            default: ph_q <= '0;
          endcase
        end
        StDone: begin
          yk      <= x_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/biquad_cascade.md
BIQUAD_CASCADE -- requirements
Module: biquad_cascade

Interface
REQ-001 Parameter N, default 16: signed two's-complement sample/coefficient width.
REQ-002 Parameter FRAC, default 8: fractional bits of sample and coefficient fixed-point format (FRAC < N).
REQ-003 Parameter SECTIONS, default 2: number of cascaded second-order sections (1..8).
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: request to filter uk; sampled only in IDLE.
REQ-007 Port uk  input  N: input sample, signed Q(N-FRAC).FRAC.
REQ-008 Port coef_we  input  1: coefficient write strobe.
REQ-009 Port coef_addr  input  clog2(5*SECTIONS): address 5*s+k; k=0 b0, 1 b1, 2 b2, 3 a1, 4 a2.
REQ-010 Port coef_data  input  N: signed coefficient, same Q format as samples.
REQ-011 Port clr_state  input  1: zero all delay lines; honoured only in IDLE.
REQ-012 Port busy  output  1: high from start acceptance until done.
REQ-013 Port done  output  1: one-cycle pulse when yk holds a new result.
REQ-014 Port yk  output  N: filtered output sample, held between results.
REQ-015 Port ovf  output  1: sticky saturation flag.

Function
REQ-016 Each section s SHALL compute direct form II: f = x - a1*f1 - a2*f2; y = b0*f + b1*f1 + b2*f2; x of section 0 is uk, x of section s+1 is y of section s; yk is y of the last section.
REQ-017 One shared multiplier and one accumulator SHALL be used; at most one product per cycle.
REQ-018 Products SHALL be 2N bits, arithmetically shifted right by FRAC (truncation toward -inf) before accumulation; accumulator width N+4.
REQ-019 Writes of f and of section output y SHALL saturate to [-2^(N-1), 2^(N-1)-1]; any saturation sets ovf, which clears only on reset.
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1 (uk latched); RUN->DONE after last section; DONE->IDLE unconditionally after one cycle.
REQ-021 RUN SHALL spend exactly 6 cycles per section: C0 acc=x; C1 acc-=a1*f1; C2 acc-=a2*f2; C3 f=sat(acc), acc=b1*f1; C4 acc+=b2*f2; C5 acc+=b0*f, x=sat(acc), f2<=f1, f1<=f.
REQ-022 Latency: done high and yk updated in the cycle 6*SECTIONS+1 edges after the edge sampling start; busy high for those 6*SECTIONS+1 cycles.
REQ-023 start while busy SHALL be ignored (no queueing); start may be reasserted in the DONE cycle but is only accepted in the next IDLE cycle.
REQ-024 coef_we SHALL write in IDLE only; writes while busy or to addresses >= 5*SECTIONS SHALL be ignored.
REQ-025 clr_state and start in the same IDLE cycle: clear takes effect first, computation uses zeroed delay lines.
REQ-026 coef_we and start in the same IDLE cycle: write takes effect before the computation begins.

Reset
REQ-027 reset SHALL force IDLE, busy=0, done=0, yk=0, ovf=0, all delay lines and accumulator 0, in any state including mid-computation.
REQ-028 reset SHALL load every section to pass-through: b0=1<<FRAC, b1=b2=a1=a2=0.
REQ-029 reset overrides start, coef_we and clr_state in the same cycle.

Verification (N=16, FRAC=8, SECTIONS=2)
REQ-030 After reset, start with uk=0x0100 -> done 13 cycles later, yk=0x0100, ovf=0.
REQ-031 Write addr0 (s0 b0)=0x0080, start uk=0x0200 -> yk=0x0100.
REQ-032 Write addr3 (s0 a1)=0xFF80, impulse uk=0x0100,0x0000,0x0000 -> yk 0x0100, 0x0080, 0x0040.
REQ-033 Write addr0=0x0400, start uk=0x4000 -> yk=0x7FFF, ovf=1 and stays 1 on following passes.
REQ-034 start, then start again and coef_we at cycle 3 -> single done, coefficient unchanged; reset at cycle 5 of a run -> busy=0, no done, yk=0.
REQ-035 clr_state after REQ-032 impulse -> next start with uk=0 gives yk=0x0000.
